// File: rtl/lowbus_ctrl.sv
// lowbus_ctrl: arbitrates two requesters onto the strobed inter-FPGA DATA bus.
// Each transaction runs SETUP -> STROBE -> HOLD -> DONE with registered W/R/DATA_OE.
// Optional feature macro: LOWBUS_READ_EN (defined = reads run on the bus,
// undefined = read requests complete immediately with RDATA = 8'h00).
module lowbus_ctrl #(
  parameter int unsigned SETUP_CYC  = 2,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_wdata,
  output logic       a_ack,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       w,
  output logic       r,
  output logic [7:0] data_o,
  output logic       data_oe,
  input  logic [7:0] data_i
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DW    = 8;

`ifdef LOWBUS_READ_EN
  localparam bit READ_EN = 1'b1;
`else
  localparam bit READ_EN = 1'b0;
`endif

  // Phase lengths: truncated to the counter width, zero behaves as one cycle.
  localparam logic [CNT_W-1:0] SETUP_LEN  = (CNT_W'(SETUP_CYC)  == '0) ? CNT_W'(1) : CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] STROBE_LEN = (CNT_W'(STROBE_CYC) == '0) ? CNT_W'(1) : CNT_W'(STROBE_CYC);
  localparam logic [CNT_W-1:0] HOLD_LEN   = (CNT_W'(HOLD_CYC)   == '0) ? CNT_W'(1) : CNT_W'(HOLD_CYC);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             gnt_b, gnt_n;      // current/last granted requester (1 = B)
  logic             we_q, we_n;
  logic [DW-1:0]    wdata_q, wdata_n;
  logic             w_n, r_n, oe_n, a_ack_n, b_ack_n;
  logic [DW-1:0]    data_o_n, rdata_n;
  logic [CNT_W-1:0] phase_len;
  logic             phase_last;
  logic             win_b;
  logic             sel_we;
  logic [DW-1:0]    sel_wdata;

  // Round-robin winner and per-phase terminal count.
  always_comb begin
    win_b     = b_req & (~a_req | ~gnt_b);
    sel_we    = win_b ? b_we : a_we;
    sel_wdata = win_b ? b_wdata : a_wdata;
    phase_len = CNT_W'(1);
    case (state)
      S_SETUP:  phase_len = SETUP_LEN;
      S_STROBE: phase_len = STROBE_LEN;
      S_HOLD:   phase_len = HOLD_LEN;
      default:  phase_len = CNT_W'(1);
    endcase
    phase_last = (cnt == phase_len - CNT_W'(1));
  end

  // Next state and next registered outputs.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    gnt_n    = gnt_b;
    we_n     = we_q;
    wdata_n  = wdata_q;
    w_n      = 1'b0;
    r_n      = 1'b0;
    oe_n     = 1'b0;
    data_o_n = data_o;
    rdata_n  = rdata;
    a_ack_n  = 1'b0;
    b_ack_n  = 1'b0;

    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (a_req || b_req) begin
          gnt_n   = win_b;
          we_n    = sel_we;
          wdata_n = sel_wdata;
          if (sel_we) begin
            state_n  = S_SETUP;
            oe_n     = 1'b1;
            data_o_n = sel_wdata;
          end else if (READ_EN) begin
            state_n = S_SETUP;
          end else begin
            state_n = S_DONE;
          end
        end
      end
      S_SETUP: begin
        oe_n = we_q;
        if (phase_last) begin
          state_n = S_STROBE;
          cnt_n   = '0;
          w_n     = we_q;
          r_n     = READ_EN & ~we_q;
        end
      end
      S_STROBE: begin
        oe_n = we_q;
        if (phase_last) begin
          state_n = S_HOLD;
          cnt_n   = '0;
          if (READ_EN && !we_q) rdata_n = data_i;
        end else begin
          w_n = we_q;
          r_n = READ_EN & ~we_q;
        end
      end
      S_HOLD: begin
        oe_n = we_q;
        if (phase_last) begin
          state_n = S_DONE;
          cnt_n   = '0;
          oe_n    = 1'b0;
          a_ack_n = ~gnt_b;
          b_ack_n = gnt_b;
        end
      end
      S_DONE: begin
        cnt_n = '0;
        if (a_ack || b_ack) begin
          state_n = S_IDLE;
        end else begin
          // Bus-less read completion: acknowledge one cycle after the grant.
          a_ack_n = ~gnt_b;
          b_ack_n = gnt_b;
          rdata_n = '0;
        end
      end
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      gnt_b   <= 1'b1;
      we_q    <= 1'b0;
      wdata_q <= '0;
      w       <= 1'b0;
      r       <= 1'b0;
      data_oe <= 1'b0;
      data_o  <= '0;
      rdata   <= '0;
      a_ack   <= 1'b0;
      b_ack   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      gnt_b   <= gnt_n;
      we_q    <= we_n;
      wdata_q <= wdata_n;
      w       <= w_n;
      r       <= r_n;
      data_oe <= oe_n;
      data_o  <= data_o_n;
      rdata   <= rdata_n;
      a_ack   <= a_ack_n;
      b_ack   <= b_ack_n;
      busy    <= (state_n != S_IDLE);
    end
  end

endmodule

// File: tb/tb_lowbus_ctrl.sv
// Bench for lowbus_ctrl: dut0 uses default timing, dut1 uses all-zero phase parameters.
// Expected acks are queued at issue time; a negedge monitor checks them as they appear.
module tb_lowbus_ctrl;

`ifdef LOWBUS_READ_EN
  localparam bit RD_EN = 1'b1;
`else
  localparam bit RD_EN = 1'b0;
`endif

  logic       clk;
  logic [1:0] rst_n_v, a_req_v, b_req_v, a_we_v, b_we_v;
  logic [1:0] a_ack_v, b_ack_v, busy_v, w_v, r_v, oe_v;
  logic [7:0] a_wdata_v [2];
  logic [7:0] b_wdata_v [2];
  logic [7:0] data_i_v  [2];
  logic [7:0] data_o_v  [2];
  logic [7:0] rdata_v   [2];

  lowbus_ctrl u_dut0 (
    .clk(clk), .rst_n(rst_n_v[0]),
    .a_req(a_req_v[0]), .a_we(a_we_v[0]), .a_wdata(a_wdata_v[0]), .a_ack(a_ack_v[0]),
    .b_req(b_req_v[0]), .b_we(b_we_v[0]), .b_wdata(b_wdata_v[0]), .b_ack(b_ack_v[0]),
    .rdata(rdata_v[0]), .busy(busy_v[0]), .w(w_v[0]), .r(r_v[0]),
    .data_o(data_o_v[0]), .data_oe(oe_v[0]), .data_i(data_i_v[0])
  );

  lowbus_ctrl #(.SETUP_CYC(0), .STROBE_CYC(0), .HOLD_CYC(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n_v[1]),
    .a_req(a_req_v[1]), .a_we(a_we_v[1]), .a_wdata(a_wdata_v[1]), .a_ack(a_ack_v[1]),
    .b_req(b_req_v[1]), .b_we(b_we_v[1]), .b_wdata(b_wdata_v[1]), .b_ack(b_ack_v[1]),
    .rdata(rdata_v[1]), .busy(busy_v[1]), .w(w_v[1]), .r(r_v[1]),
    .data_o(data_o_v[1]), .data_oe(oe_v[1]), .data_i(data_i_v[1])
  );

  typedef struct {
    bit         is_b;
    bit         we;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         ack, wf, wl, rf, rl, of, ol;
  } txn_t;

  txn_t       sbq0 [$];
  txn_t       sbq1 [$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] exp_rd [2];

  // Monitor-side observation windows (cycle numbers, -1 = never seen).
  int         wf_m [2], wl_m [2], rf_m [2], rl_m [2], of_m [2], ol_m [2];
  logic [7:0] oe_dat [2];
  bit         oe_bad [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  task automatic chk(input string nm, input int d, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h (cyc %0d)", nm, d, act, exp, cyc);
    end
  endtask

  function automatic txn_t mk(input int d, input bit is_b, input bit we,
                              input logic [7:0] wdata, input logic [7:0] din, input int g);
    txn_t t;
    int s, tt, h, p;
    s  = (d == 0) ? 2 : 1;
    tt = (d == 0) ? 2 : 1;
    h  = 1;
    p  = s + tt + h;
    t.is_b = is_b; t.we = we; t.wdata = wdata; t.rdata = exp_rd[d];
    t.wf = -1; t.wl = -1; t.rf = -1; t.rl = -1; t.of = -1; t.ol = -1;
    if (we) begin
      t.of = g; t.ol = g + p - 1; t.wf = g + s; t.wl = g + s + tt - 1; t.ack = g + p;
    end else if (RD_EN) begin
      t.rf = g + s; t.rl = g + s + tt - 1; t.ack = g + p; t.rdata = din;
    end else begin
      t.ack = g + 1; t.rdata = 8'h00;
    end
    return t;
  endfunction

  task automatic push(input int d, input txn_t t);
    exp_rd[d] = t.rdata;
    if (d == 0) sbq0.push_back(t);
    else        sbq1.push_back(t);
  endtask

  task automatic clr_win(input int d);
    wf_m[d] = -1; wl_m[d] = -1; rf_m[d] = -1; rl_m[d] = -1;
    of_m[d] = -1; ol_m[d] = -1; oe_bad[d] = 1'b0; oe_dat[d] = 8'h00;
  endtask

  // Scoreboard monitor: protocol invariants each cycle, ack contents on completion.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n_v[d]) begin
        clr_win(d);
      end else begin
        txn_t e;
        int   qn;
        chk("w_and_r", d, int'(w_v[d] & r_v[d]), 0);
        chk("oe_and_r", d, int'(oe_v[d] & r_v[d]), 0);
        if (w_v[d])  begin if (wf_m[d] < 0) wf_m[d] = cyc; wl_m[d] = cyc; end
        if (r_v[d])  begin if (rf_m[d] < 0) rf_m[d] = cyc; rl_m[d] = cyc; end
        if (oe_v[d]) begin
          if (of_m[d] < 0) oe_dat[d] = data_o_v[d];
          else if (data_o_v[d] != oe_dat[d]) oe_bad[d] = 1'b1;
          if (of_m[d] < 0) of_m[d] = cyc;
          ol_m[d] = cyc;
        end
        if (a_ack_v[d] || b_ack_v[d]) begin
          qn = (d == 0) ? sbq0.size() : sbq1.size();
          if (qn == 0 || (a_ack_v[d] && b_ack_v[d])) begin
            chk("unexpected_ack", d, {30'd0, a_ack_v[d], b_ack_v[d]}, 0);
          end else begin
            e = (d == 0) ? sbq0.pop_front() : sbq1.pop_front();
            chk("ack_who",   d, int'(b_ack_v[d]), int'(e.is_b));
            chk("ack_cycle", d, cyc, e.ack);
            chk("rdata",     d, int'(rdata_v[d]), int'(e.rdata));
            chk("w_first",   d, wf_m[d], e.wf);
            chk("w_last",    d, wl_m[d], e.wl);
            chk("r_first",   d, rf_m[d], e.rf);
            chk("r_last",    d, rl_m[d], e.rl);
            chk("oe_first",  d, of_m[d], e.of);
            chk("oe_last",   d, ol_m[d], e.ol);
            if (e.we) begin
              chk("oe_data",   d, int'(oe_dat[d]), int'(e.wdata));
              chk("oe_stable", d, int'(oe_bad[d]), 0);
            end
          end
          clr_win(d);
        end
      end
    end
  end

  task automatic wait_ack(input int d, input bit is_b, input bit scramble);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (scramble && i == 0) begin
        if (is_b) begin b_we_v[d] = ~b_we_v[d]; b_wdata_v[d] = ~b_wdata_v[d]; end
        else      begin a_we_v[d] = ~a_we_v[d]; a_wdata_v[d] = ~a_wdata_v[d]; end
      end
      if (is_b ? b_ack_v[d] : a_ack_v[d]) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_timeout", d, int'(got), 1);
  endtask

  // One transaction from an idle controller; WE/WDATA are flipped after the grant.
  task automatic txn(input int d, input bit is_b, input bit we,
                     input logic [7:0] wdata, input logic [7:0] din);
    @(negedge clk);
    if (is_b) begin b_req_v[d] = 1'b1; b_we_v[d] = we; b_wdata_v[d] = wdata; end
    else      begin a_req_v[d] = 1'b1; a_we_v[d] = we; a_wdata_v[d] = wdata; end
    data_i_v[d] = din;
    push(d, mk(d, is_b, we, wdata, din, cyc + 1));
    wait_ack(d, is_b, 1'b1);
    if (is_b) b_req_v[d] = 1'b0;
    else      a_req_v[d] = 1'b0;
  endtask

  task automatic chk_reset_state(input int d);
    chk("rst_w",      d, int'(w_v[d]), 0);
    chk("rst_r",      d, int'(r_v[d]), 0);
    chk("rst_oe",     d, int'(oe_v[d]), 0);
    chk("rst_data_o", d, int'(data_o_v[d]), 0);
    chk("rst_rdata",  d, int'(rdata_v[d]), 0);
    chk("rst_acks",   d, int'({a_ack_v[d], b_ack_v[d]}), 0);
    chk("rst_busy",   d, int'(busy_v[d]), 0);
  endtask

  initial begin
    int k;
    rst_n_v = 2'b00; a_req_v = '0; b_req_v = '0; a_we_v = '0; b_we_v = '0;
    for (int d = 0; d < 2; d++) begin
      a_wdata_v[d] = 8'h00; b_wdata_v[d] = 8'h00; data_i_v[d] = 8'h00;
      exp_rd[d] = 8'h00; clr_win(d);
    end
    // Both requesters of dut0 high from reset: grant order A, B, A, B.
    a_req_v[0] = 1'b1; a_we_v[0] = 1'b1; a_wdata_v[0] = 8'h11;
    b_req_v[0] = 1'b1; b_we_v[0] = 1'b1; b_wdata_v[0] = 8'h22;
    repeat (3) @(negedge clk);
    chk_reset_state(0);
    chk_reset_state(1);
    rst_n_v = 2'b11;
    k = cyc + 1;
    push(0, mk(0, 1'b0, 1'b1, 8'h11, 8'h00, k));
    push(0, mk(0, 1'b1, 1'b1, 8'h22, 8'h00, k + 7));
    push(0, mk(0, 1'b0, 1'b1, 8'h33, 8'h00, k + 14));
    push(0, mk(0, 1'b1, 1'b1, 8'h44, 8'h00, k + 21));
    fork
      begin
        wait_ack(0, 1'b0, 1'b0);
        a_req_v[0] = 1'b0;
        @(negedge clk);
        a_wdata_v[0] = 8'h33; a_req_v[0] = 1'b1;
        wait_ack(0, 1'b0, 1'b0);
        a_req_v[0] = 1'b0;
      end
      begin
        wait_ack(0, 1'b1, 1'b0);
        b_req_v[0] = 1'b0;
        @(negedge clk);
        b_wdata_v[0] = 8'h44; b_req_v[0] = 1'b1;
        wait_ack(0, 1'b1, 1'b0);
        b_req_v[0] = 1'b0;
      end
    join

    // Directed single transactions on default timing.
    txn(0, 1'b0, 1'b1, 8'h5A, 8'h00);
    txn(0, 1'b1, 1'b0, 8'h00, 8'hC3);
    txn(0, 1'b0, 1'b0, 8'h00, 8'h96);
    txn(0, 1'b1, 1'b1, 8'hA5, 8'h00);

    // Reset during the write strobe aborts without an ack.
    @(negedge clk);
    a_req_v[0] = 1'b1; a_we_v[0] = 1'b1; a_wdata_v[0] = 8'h77;
    k = cyc + 1;
    repeat (3) @(negedge clk);
    rst_n_v[0] = 1'b0; a_req_v[0] = 1'b0;
    @(negedge clk);
    chk("abort_w",    0, int'(w_v[0]), 0);
    chk("abort_oe",   0, int'(oe_v[0]), 0);
    chk("abort_busy", 0, int'(busy_v[0]), 0);
    chk("abort_ack",  0, int'(a_ack_v[0]), 0);
    chk("abort_rdata", 0, int'(rdata_v[0]), 0);
    rst_n_v[0] = 1'b1;
    exp_rd[0] = 8'h00;
    txn(0, 1'b0, 1'b1, 8'h3C, 8'h00);

    // Zero-valued phase parameters: one cycle per phase.
    txn(1, 1'b0, 1'b1, 8'hE1, 8'h00);
    txn(1, 1'b1, 1'b0, 8'h00, 8'h7E);

    repeat (4) @(negedge clk);
    chk("sb_drained", 0, sbq0.size(), 0);
    chk("sb_drained", 1, sbq1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
